// File: rtl/mcs4_pkg.sv
// Shared timing defaults for the MCS-4 two-phase clock generator.
// Holds the default PHI period, both PHI low windows and the frame length.
package mcs4_pkg;

    localparam int DEF_PERIOD     = 7;
    localparam int DEF_PHI1_START = 0;
    localparam int DEF_PHI1_LEN   = 2;
    localparam int DEF_PHI2_START = 4;
    localparam int DEF_PHI2_LEN   = 2;
    localparam int DEF_STATES     = 8;

    // True when tick c falls inside the window [s, s+l-1].
    function automatic logic in_window(input int c, input int s, input int l);
        return (c >= s) && (c < s + l);
    endfunction

endpackage

// File: rtl/mcs4_mod_counter.sv
// Modulo-MOD up counter with enable and synchronous active-high reset.
// Ports: clk_i, rst_i, en_i in; count (current value), wrap (en_i at MOD-1) out.
module mcs4_mod_counter #(
    parameter int MOD = 8,
    localparam int W = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q = '0;

    assign count = count_q;
    assign wrap  = en_i && (count_q == W'(MOD - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= wrap ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/mcs4_phase_gen.sv
// Two-phase non-overlapping PHI1/PHI2 generator with frame SYNC and stop control.
// Ports: clk_i, rst_i (sync, active-high), run_i in; PHI1_o, PHI2_o, SYNC_o
// (active-low), state_o (subcycle index), stopped_o out. All outputs registered.
// Macro MCS4_PHASE_GEN_SYNC_EN enables the subcycle counter, SYNC_o and state_o;
// without it SYNC_o is tied high and state_o tied to zero.
module mcs4_phase_gen
    import mcs4_pkg::*;
#(
    parameter int PERIOD     = DEF_PERIOD,
    parameter int PHI1_START = DEF_PHI1_START,
    parameter int PHI1_LEN   = DEF_PHI1_LEN,
    parameter int PHI2_START = DEF_PHI2_START,
    parameter int PHI2_LEN   = DEF_PHI2_LEN,
    parameter int STATES     = DEF_STATES,
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1,
    localparam int SW = (STATES > 1) ? $clog2(STATES) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          run_i,
    output logic          PHI1_o,
    output logic          PHI2_o,
    output logic          SYNC_o,
    output logic [SW-1:0] state_o,
    output logic          stopped_o
);

    if (PERIOD < 2) begin : g_bad_period
        $error("PERIOD must be at least 2");
    end
    if (STATES < 2) begin : g_bad_states
        $error("STATES must be at least 2");
    end
    if (PHI1_LEN < 1 || PHI2_LEN < 1) begin : g_bad_len
        $error("PHI window lengths must be nonzero");
    end
    if (PHI1_START < 0 || PHI1_START + PHI1_LEN > PERIOD) begin : g_bad_w1
        $error("PHI1 window exceeds the period");
    end
    if (PHI2_START < 0 || PHI2_START + PHI2_LEN > PERIOD) begin : g_bad_w2
        $error("PHI2 window exceeds the period");
    end
    if ((PHI1_START < PHI2_START + PHI2_LEN) &&
        (PHI2_START < PHI1_START + PHI1_LEN)) begin : g_overlap
        $error("PHI1 and PHI2 windows overlap");
    end

    logic [CW-1:0] cnt;
    logic          cnt_wrap;
    logic          active;
    logic          phi1_hit;
    logic          phi2_hit;

    // A stop request only takes effect once the period returns to tick 0.
    assign active   = run_i || (cnt != '0);
    assign phi1_hit = active && in_window(int'(cnt), PHI1_START, PHI1_LEN);
    assign phi2_hit = active && in_window(int'(cnt), PHI2_START, PHI2_LEN);

    mcs4_mod_counter #(.MOD(PERIOD)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (active),
        .count (cnt),
        .wrap  (cnt_wrap)
    );

    logic phi1_q    = 1'b1;
    logic phi2_q    = 1'b1;
    logic stopped_q = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phi1_q    <= 1'b1;
            phi2_q    <= 1'b1;
            stopped_q <= 1'b0;
        end else begin
            phi1_q    <= !phi1_hit;
            phi2_q    <= !phi2_hit;
            stopped_q <= !active;
        end
    end

    assign PHI1_o    = phi1_q;
    assign PHI2_o    = phi2_q;
    assign stopped_o = stopped_q;

`ifdef MCS4_PHASE_GEN_SYNC_EN
    logic [SW-1:0] state;
    logic          state_wrap_unused;
    logic          sync_q  = 1'b1;
    logic [SW-1:0] state_q = '0;

    mcs4_mod_counter #(.MOD(STATES)) u_state (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (cnt_wrap),
        .count (state),
        .wrap  (state_wrap_unused)
    );

    // Registered alongside the PHI decode so SYNC_o lines up with state_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 1'b1;
            state_q <= '0;
        end else begin
            sync_q  <= (state != SW'(STATES - 1));
            state_q <= state;
        end
    end

    assign SYNC_o  = sync_q;
    assign state_o = state_q;
`else
    logic cnt_wrap_unused;

    assign cnt_wrap_unused = cnt_wrap;
    assign SYNC_o  = 1'b1;
    assign state_o = '0;
`endif

endmodule

// File: tb/tb_mcs4_phase_gen.sv
// Self-checking bench for mcs4_phase_gen: default and PERIOD=10 instances
// compared each clock against a tick/frame reference model.
module tb_mcs4_phase_gen;

`ifdef MCS4_PHASE_GEN_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;

    logic       phi1_0, phi2_0, sync_0, stop_0;
    logic [2:0] st_0;
    logic       phi1_1, phi2_1, sync_1, stop_1;
    logic [1:0] st_1;

    always #5 clk = ~clk;

    mcs4_phase_gen dut0 (
        .clk_i     (clk),
        .rst_i     (rst),
        .run_i     (run),
        .PHI1_o    (phi1_0),
        .PHI2_o    (phi2_0),
        .SYNC_o    (sync_0),
        .state_o   (st_0),
        .stopped_o (stop_0)
    );

    mcs4_phase_gen #(
        .PERIOD     (10),
        .PHI1_START (1),
        .PHI1_LEN   (3),
        .PHI2_START (6),
        .PHI2_LEN   (2),
        .STATES     (4)
    ) dut1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .run_i     (run),
        .PHI1_o    (phi1_1),
        .PHI2_o    (phi2_1),
        .SYNC_o    (sync_1),
        .state_o   (st_1),
        .stopped_o (stop_1)
    );

    // Reference model parameters per instance.
    int P  [2] = '{7, 10};
    int S1 [2] = '{0, 1};
    int L1 [2] = '{2, 3};
    int S2 [2] = '{4, 6};
    int L2 [2] = '{2, 2};
    int NS [2] = '{8, 4};

    int pos   [2];
    int frame [2];
    int e_phi1 [2];
    int e_phi2 [2];
    int e_sync [2];
    int e_st   [2];
    int e_stop [2];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit rs);
        bit act;
        for (int d = 0; d < 2; d++) begin
            if (rs) begin
                pos[d] = 0; frame[d] = 0;
                e_phi1[d] = 1; e_phi2[d] = 1; e_sync[d] = 1;
                e_st[d] = 0; e_stop[d] = 0;
            end else begin
                act = r || (pos[d] != 0);
                e_phi1[d] = (act && pos[d] >= S1[d] && pos[d] < S1[d] + L1[d]) ? 0 : 1;
                e_phi2[d] = (act && pos[d] >= S2[d] && pos[d] < S2[d] + L2[d]) ? 0 : 1;
                e_stop[d] = act ? 0 : 1;
                e_sync[d] = (SYNC_EN && frame[d] == NS[d] - 1) ? 0 : 1;
                e_st[d]   = SYNC_EN ? frame[d] : 0;
                if (act) begin
                    if (pos[d] == P[d] - 1) begin
                        pos[d] = 0;
                        frame[d] = (frame[d] + 1) % NS[d];
                    end else begin
                        pos[d]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("d0_phi1", phi1_0, e_phi1[0]);
        chk("d0_phi2", phi2_0, e_phi2[0]);
        chk("d0_sync", sync_0, e_sync[0]);
        chk("d0_state", st_0, e_st[0]);
        chk("d0_stopped", stop_0, e_stop[0]);
        chk("d0_overlap", phi1_0 | phi2_0, 1);
        chk("d1_phi1", phi1_1, e_phi1[1]);
        chk("d1_phi2", phi2_1, e_phi2[1]);
        chk("d1_sync", sync_1, e_sync[1]);
        chk("d1_state", st_1, e_st[1]);
        chk("d1_stopped", stop_1, e_stop[1]);
        chk("d1_overlap", phi1_1 | phi2_1, 1);
    endtask

    task automatic step(input bit r, input bit rs);
        run = r;
        rst = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        check_all();
    endtask

    initial begin
        int low1;
        int low2;
        bit found;

        // Power-up values before any reset edge.
        #1;
        chk("init_phi1", phi1_0, 1);
        chk("init_phi2", phi2_0, 1);
        chk("init_sync", sync_0, 1);
        chk("init_state", st_0, 0);
        chk("init_stopped", stop_0, 0);

        step(0, 1);
        step(0, 1);
        chk("rst_phi1", phi1_0, 1);
        chk("rst_stopped", stop_0, 0);

        // Free run from reset: exact PHI1/PHI2 positions of the defaults.
        for (int k = 1; k <= 70; k++) begin
            step(1, 0);
            chk("def_phi1_pos", phi1_0, (((k - 1) % 7) < 2) ? 1'b0 : 1'b1);
            chk("def_phi2_pos", phi2_0,
                (((k - 1) % 7) == 4 || ((k - 1) % 7) == 5) ? 1'b0 : 1'b1);
        end

        // PERIOD=10 instance: count low clocks over one full period.
        low1 = 0;
        low2 = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 0);
            if (phi1_1 == 1'b0) low1++;
            if (phi2_1 == 1'b0) low2++;
        end
        chk("p10_phi1_width", 8'(low1), 3);
        chk("p10_phi2_width", 8'(low2), 2);

        // Drop run at cnt=3 of the default instance.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (pos[0] == 3) found = 1;
            else step(1, 0);
        end
        chk("align_cnt3", 8'(found), 1);
        for (int k = 0; k < 4; k++) step(0, 0);
        chk("stop_after_period", stop_0, 0);
        for (int k = 0; k < 12; k++) step(0, 0);
        chk("stopped_held", stop_0, 1);
        chk("stopped_phi1", phi1_0, 1);
        chk("stopped_phi2", phi2_0, 1);
        step(1, 0);
        chk("restart_phi1", phi1_0, 0);
        chk("restart_stopped", stop_0, 0);

        // Reset in the middle of a PHI1 low window.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (phi1_0 == 1'b0 && pos[0] == 1) found = 1;
            else step(1, 0);
        end
        chk("find_phi1_low", 8'(found), 1);
        step(1, 1);
        chk("midrst_phi1", phi1_0, 1);
        chk("midrst_state", st_0, 0);
        step(1, 0);
        chk("post_rst_phi1", phi1_0, 0);

        // Randomized run/reset traffic.
        for (int k = 0; k < 500; k++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
